// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// FSM state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is configurable; defaults to 1 for idle-high lines.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture to settle metastability
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8-N-1 UART receiver with one-clock done pulse.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            w_rxs;
  logic            r_rxs_d;
  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic            r_done;
  logic [DBIT-1:0] r_dout;
  logic            r_ferr;
`ifdef UART_RX_PARITY_EN
  logic            r_par;
  logic            r_perr;
`endif

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk  (clk),
    .i_reset(reset),
    .i_d    (rx),
    .o_q    (w_rxs)
  );

  // Previous synced sample for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxs_d <= 1'b1;
    end else begin
      r_rxs_d <= w_rxs;
    end
  end

  // Frame FSM: start check, data shift, optional parity, stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == S_MID) begin
              if (!w_rxs) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == S_LAST) begin
              r_s <= '0;
              r_b <= {w_rxs, r_b[DBIT-1:1]};
              if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (r_s == S_LAST) begin
              r_par   <= w_rxs;
              r_s     <= '0;
              r_state <= STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (r_s == S_STOP) begin
              r_done  <= 1'b1;
              r_dout  <= r_b;
              r_ferr  <= ~w_rxs;
`ifdef UART_RX_PARITY_EN
              r_perr  <= ^r_b ^ r_par;
`endif
              r_state <= IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path: oversamples the `rx` line at 16x the baud rate, recovers one 8-N-1 character at a time and presents it on `dout` with a one-clock `rx_done_tick`. The block sits directly upstream of the flag/buffer interface. `rx_done_tick` drives that stage's `set_flag`, and `dout` drives its `din`. The 16x `s_tick` comes from the shared baud-rate generator.

## Interface
- `DBIT`, 8: data bits per character (LSB first).
- `SB_TICK`, 16: `s_tick` count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: serial input, asynchronous to `clk`; idle high.
- `s_tick`  in  1: one-`clk` pulse at 16x baud.
- `rx_done_tick`  out  1: one-`clk` pulse when a character is complete.
- `dout`  out  DBIT: last completed character; holds until the next completion.
- `frame_err`  out  1: stop-bit sample of the last character was 0; updated at each `rx_done_tick`.
- `parity_err`  out  1: parity mismatch on the last character (see Configuration); updated at each `rx_done_tick`.

## Operation
- `rx` passes through a 2-flop synchronizer. The FSM reads the synced value `rxs` and its previous value `rxs_d`.
- Reset values:
  - state = IDLE; all counters = 0; shift register = 0.
  - `rx_done_tick` = 0, `dout` = 0, `frame_err` = 0, `parity_err` = 0.
  - `rxs` and `rxs_d` = 1.
- Counters:
  - `s`: 4-bit tick counter, wraps naturally.
  - `n`: data-bit counter, width $clog2(DBIT).
  - Stop-tick counter: reuses `s`, widened to 5 bits when `SB_TICK` > 16.
- States and transitions:
  - IDLE: on a falling edge (`rxs_d`=1, `rxs`=0) go to START with `s`=0. A line that stays low (break) does not retrigger.
  - START: on each `s_tick`, `s++`. At `s`=7 (mid start bit):
    - if `rxs`=0, go to DATA with `s`=0, `n`=0;
    - if `rxs`=1, treat as a glitch and return to IDLE with no output.
  - DATA: on each `s_tick`, `s++`. At `s`=15:
    - shift in `b = {rxs, b[DBIT-1:1]}` and set `s`=0;
    - if `n`=DBIT-1, go to PARITY (macro defined) or STOP; otherwise `n++`.
  - PARITY (macro only): at `s`=15 latch `par_bit = rxs`, set `s`=0, go to STOP.
  - STOP: at `s`=SB_TICK-1:
    - pulse `rx_done_tick`;
    - `dout <= b`;
    - `frame_err <= ~rxs`;
    - `parity_err <=` computed value (or 0);
    - return to IDLE.
- A frame with a framing error still completes. `rx_done_tick` fires and `dout` is updated; the downstream stage decides what to do with it.
- `s_tick` absent: the FSM holds its state indefinitely. There is no timeout.
- Asynchronous `reset` mid-frame: return to IDLE immediately, with no `rx_done_tick` and `dout` cleared to 0.

## Timing
- Synchronizer latency: 2 `clk` from an `rx` edge to `rxs`.
- Sampling points are mid-bit: the start bit at tick 8 after the detected edge, then each data bit 16 ticks later.
- `rx_done_tick` is high for exactly one `clk`. It occurs in the cycle after the `s_tick` that ends the stop bit.
- `dout`, `frame_err` and `parity_err` change in the same edge that raises `rx_done_tick`, and are stable otherwise.
- Back-to-back frames: IDLE can detect a new start edge in the cycle after STOP exits.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state is compiled in, adding one 16-tick parity bit after the data bits;
  - parity is even: `parity_err <= ^b ^ par_bit`.
- `UART_RX_PARITY_EN` undefined:
  - no PARITY state; DATA goes straight to STOP;
  - the `parity_err` port remains and is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - constants `OVERSAMPLE`=16 and `MID_TICK`=7.
- One sub-module: `sync_2ff`, the 2-flop synchronizer for `rx`, reset to 1. It is reusable for other asynchronous inputs.

## Test plan
- Bench setup: `s_tick` every 16 `clk`; `rx` driven at 256 `clk` per bit.
1. Send 0xA5 with stop=1 -> exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0.
2. Low glitch of 4 ticks on idle `rx` -> no `rx_done_tick`, FSM back in IDLE, `dout` unchanged.
3. Send 0x3C with stop bit forced 0 -> `rx_done_tick` fires, `dout`=0x3C, `frame_err`=1. Line held low afterwards -> no second tick until `rx` goes high and falls again.
4. Back-to-back 0x01 then 0xFF with no idle gap -> two ticks, `dout` = 0x01 then 0xFF, `frame_err`=0 both times.
5. Assert `reset` during data bit 4 of 0x55 -> no `rx_done_tick`, `dout`=0. A following 0x55 is received correctly.
6. With `UART_RX_PARITY_EN`: send 0x03 with parity bit 0 -> `parity_err`=0; send 0x03 with parity bit 1 -> `parity_err`=1, `dout`=0x03.
